// File: rtl/burst_addr_arbiter.sv
// Two-port burst address generator with round-robin arbitration and periodic refresh.
// Refresh preempts requesters only between bursts; all outputs are registered.
module burst_addr_arbiter #(
  parameter int ADDR_BITS        = 8,
  parameter int LEN_BITS         = 4,
  parameter int REFRESH_INTERVAL = 64,
  parameter int REFRESH_CYCLES   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0,
  input  logic                 req1,
  input  logic [ADDR_BITS-1:0] start0,
  input  logic [ADDR_BITS-1:0] start1,
  input  logic [LEN_BITS-1:0]  len0,
  input  logic [LEN_BITS-1:0]  len1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 owner,
  output logic                 addr_valid,
  output logic [ADDR_BITS-1:0] addr,
  output logic                 last,
  output logic                 busy,
  output logic                 refresh_active,
  output logic                 refresh_overrun
);

  localparam int IW = (REFRESH_INTERVAL > 2) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam int RW = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [IW-1:0] IV_LAST = IW'(REFRESH_INTERVAL - 1);
  localparam logic [RW-1:0] RC_LOAD = RW'(REFRESH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BURST   = 2'd1,
    ST_REFRESH = 2'd2
  } state_e;

  state_e                 state_q;
  logic [IW-1:0]          iv_q, iv_d;
  logic                   pend_q;
  logic                   overrun_q;
  logic [RW-1:0]          rcnt_q;
  logic [LEN_BITS-1:0]    beats_q;
  logic                   last_owner_q;
  logic                   gnt0_q, gnt1_q, owner_q, valid_q, last_q, busy_q, ref_q;
  logic [ADDR_BITS-1:0]   addr_q;

  logic                   iv_wrap;
  logic                   any_req;
  logic                   win;
  logic [ADDR_BITS-1:0]   win_start;
  logic [LEN_BITS-1:0]    win_len;
  logic                   burst_done;
  logic                   enter_ref;

  always_comb begin
    iv_wrap    = (iv_q == IV_LAST);
    iv_d       = iv_wrap ? '0 : iv_q + 1'b1;
    any_req    = req0 | req1;
    // On a tie the port that did not win last time gets the grant.
    win        = (req0 & req1) ? ~last_owner_q : req1;
    win_start  = win ? start1 : start0;
    win_len    = win ? len1 : len0;
    burst_done = (state_q == ST_BURST) && (beats_q == '0);
    enter_ref  = pend_q && ((state_q == ST_IDLE) || burst_done);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      iv_q         <= '0;
      pend_q       <= 1'b0;
      overrun_q    <= 1'b0;
      rcnt_q       <= '0;
      beats_q      <= '0;
      last_owner_q <= 1'b1;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      owner_q      <= 1'b0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      busy_q       <= 1'b0;
      ref_q        <= 1'b0;
      addr_q       <= '0;
    end else begin
      iv_q      <= iv_d;
      overrun_q <= iv_wrap & pend_q;
      if (iv_wrap)        pend_q <= 1'b1;
      else if (enter_ref) pend_q <= 1'b0;

      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;

      if (enter_ref) begin
        state_q <= ST_REFRESH;
        ref_q   <= 1'b1;
        busy_q  <= 1'b1;
        rcnt_q  <= RC_LOAD;
        valid_q <= 1'b0;
        last_q  <= 1'b0;
        owner_q <= 1'b0;
        addr_q  <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (any_req) begin
              state_q      <= ST_BURST;
              busy_q       <= 1'b1;
              valid_q      <= 1'b1;
              addr_q       <= win_start;
              beats_q      <= win_len;
              last_q       <= (win_len == '0);
              owner_q      <= win;
              gnt0_q       <= ~win;
              gnt1_q       <= win;
              last_owner_q <= win;
            end
          end
          ST_BURST: begin
            if (burst_done) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              owner_q <= 1'b0;
              addr_q  <= '0;
            end else begin
              addr_q  <= addr_q + 1'b1;
              beats_q <= beats_q - 1'b1;
              last_q  <= (beats_q == LEN_BITS'(1));
            end
          end
          ST_REFRESH: begin
            if (rcnt_q == '0) begin
              state_q <= ST_IDLE;
              ref_q   <= 1'b0;
              busy_q  <= 1'b0;
            end else begin
              rcnt_q <= rcnt_q - 1'b1;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            ref_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign gnt0            = gnt0_q;
  assign gnt1            = gnt1_q;
  assign owner           = owner_q;
  assign addr_valid      = valid_q;
  assign addr            = addr_q;
  assign last            = last_q;
  assign busy            = busy_q;
  assign refresh_active  = ref_q;
  assign refresh_overrun = overrun_q;

endmodule

// File: tb/tb_burst_addr_arbiter.sv
// Bench for burst_addr_arbiter: beat scoreboard plus directed timing checks.
module tb_burst_addr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] start0 = '0, start1 = '0;
  logic [3:0] len0 = '0, len1 = '0;
  logic       gnt0, gnt1, owner, addr_valid, last, busy, refresh_active, refresh_overrun;
  logic [7:0] addr;

  int         vec_cnt = 0;
  int         err_cnt = 0;
  int         ec;
  logic [11:0] sbq[$];

  burst_addr_arbiter #(
    .ADDR_BITS(8), .LEN_BITS(4), .REFRESH_INTERVAL(64), .REFRESH_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1),
    .start0(start0), .start1(start1),
    .len0(len0), .len1(len1),
    .gnt0(gnt0), .gnt1(gnt1), .owner(owner), .addr_valid(addr_valid),
    .addr(addr), .last(last), .busy(busy),
    .refresh_active(refresh_active), .refresh_overrun(refresh_overrun)
  );

  always #5 clk = ~clk;

  // Rising edges since reset release; sampled at the falling edge this equals N after edge N.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ec <= 0;
    else        ec <= ec + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h want %h (edge %0d)", tag, obs, exp, ec);
    end
  endtask

  function automatic logic [11:0] beat(input logic o, input logic [7:0] a, input logic l,
                                       input logic g0, input logic g1);
    return {o, a, l, g0, g1};
  endfunction

  task automatic push_burst(input logic o, input logic [7:0] st, input int n);
    logic [7:0] a;
    a = st;
    for (int i = 0; i < n; i++) begin
      sbq.push_back(beat(o, a, (i == n - 1), (i == 0) && !o, (i == 0) && o));
      a = a + 8'd1;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (addr_valid) begin
        if (sbq.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
        else chk("beat", 32'({owner, addr, last, gnt0, gnt1}), 32'(sbq.pop_front()));
      end else begin
        chk("idle_quiet", 32'({gnt0, gnt1, last, owner, addr}), 32'd0);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    sbq.delete();
    @(negedge clk);
    chk("rst_outs", 32'({gnt0, gnt1, owner, addr_valid, addr, last, busy,
                         refresh_active, refresh_overrun}), 32'd0);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_ec(input int n);
    for (int i = 0; i < 2000 && ec < n; i++) @(negedge clk);
    if (ec != n) chk("wait_ec", 32'(ec), 32'(n));
  endtask

  initial begin
    int nb;

    // 1: single read burst
    do_reset();
    release_rst();
    req0 = 1'b1; start0 = 8'h10; len0 = 4'd3;
    push_burst(1'b0, 8'h10, 4);
    wait_ec(1);
    chk("t1_gnt0", 32'(gnt0), 32'd1);
    req0 = 1'b0;
    nb = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy) nb++;
      @(negedge clk);
    end
    chk("t1_busy_cycles", 32'(nb), 32'd4);
    chk("t1_drain", 32'(sbq.size()), 32'd0);

    // 2: write burst wrapping the address space
    do_reset();
    release_rst();
    req1 = 1'b1; start1 = 8'hFE; len1 = 4'd3;
    push_burst(1'b1, 8'hFE, 4);
    wait_ec(1);
    chk("t2_gnt1", 32'(gnt1), 32'd1);
    req1 = 1'b0;
    wait_ec(8);
    chk("t2_drain", 32'(sbq.size()), 32'd0);

    // 3: both held from reset, round-robin with one dead cycle between bursts
    do_reset();
    req0 = 1'b1; start0 = 8'h20; len0 = 4'd1;
    req1 = 1'b1; start1 = 8'h40; len1 = 4'd1;
    push_burst(1'b0, 8'h20, 2);
    push_burst(1'b1, 8'h40, 2);
    push_burst(1'b0, 8'h20, 2);
    push_burst(1'b1, 8'h40, 2);
    release_rst();
    wait_ec(1);  chk("t3_gnt_a", 32'({gnt0, gnt1}), 32'b10);
    wait_ec(3);  chk("t3_dead_a", 32'({addr_valid, busy}), 32'b00);
    wait_ec(4);  chk("t3_gnt_b", 32'({gnt0, gnt1}), 32'b01);
    wait_ec(6);  chk("t3_dead_b", 32'({addr_valid, busy}), 32'b00);
    wait_ec(7);  chk("t3_gnt_c", 32'({gnt0, gnt1}), 32'b10);
    wait_ec(10); chk("t3_gnt_d", 32'({gnt0, gnt1}), 32'b01);
    wait_ec(11);
    req0 = 1'b0; req1 = 1'b0;
    wait_ec(16);
    chk("t3_drain", 32'(sbq.size()), 32'd0);

    // 4: idle refresh cadence
    do_reset();
    release_rst();
    wait_ec(64);  chk("t4_ref_64", 32'(refresh_active), 32'd0);
    wait_ec(65);  chk("t4_ref_65", 32'({refresh_active, busy}), 32'b11);
    wait_ec(68);  chk("t4_ref_68", 32'(refresh_active), 32'd1);
    wait_ec(69);  chk("t4_ref_69", 32'({refresh_active, busy}), 32'b00);
    wait_ec(128); chk("t4_ref_128", 32'(refresh_active), 32'd0);
    wait_ec(129); chk("t4_ref_129", 32'(refresh_active), 32'd1);
    wait_ec(132); chk("t4_ref_132", 32'({refresh_active, refresh_overrun}), 32'b10);
    wait_ec(133); chk("t4_ref_133", 32'(refresh_active), 32'd0);

    // 5: long burst spanning the refresh interval, held req1 served after refresh
    do_reset();
    release_rst();
    wait_ec(54);
    req0 = 1'b1; start0 = 8'hF8; len0 = 4'd15;
    push_burst(1'b0, 8'hF8, 16);
    wait_ec(55); chk("t5_gnt0", 32'(gnt0), 32'd1);
    req0 = 1'b0;
    wait_ec(60);
    req1 = 1'b1; start1 = 8'h30; len1 = 4'd2;
    push_burst(1'b1, 8'h30, 3);
    wait_ec(65); chk("t5_no_ref_mid", 32'({refresh_active, addr_valid}), 32'b01);
    wait_ec(70); chk("t5_last", 32'({last, addr}), 32'({1'b1, 8'h07}));
    wait_ec(71); chk("t5_ref_after", 32'({refresh_active, addr_valid}), 32'b10);
    wait_ec(74); chk("t5_ref_end", 32'(refresh_active), 32'd1);
    wait_ec(75); chk("t5_ref_off", 32'({refresh_active, gnt1}), 32'b00);
    wait_ec(76); chk("t5_gnt1", 32'(gnt1), 32'd1);
    req1 = 1'b0;
    wait_ec(82);
    chk("t5_drain", 32'(sbq.size()), 32'd0);

    // 6: reset in the middle of a burst, then a fresh request
    do_reset();
    release_rst();
    req0 = 1'b1; start0 = 8'h80; len0 = 4'd7;
    push_burst(1'b0, 8'h80, 8);
    wait_ec(1); chk("t6_gnt0", 32'(gnt0), 32'd1);
    req0 = 1'b0;
    wait_ec(2);
    #1 rst_n = 1'b0;
    #1 chk("t6_abort", 32'({gnt0, gnt1, owner, addr_valid, addr, last, busy,
                            refresh_active, refresh_overrun}), 32'd0);
    sbq.delete();
    @(negedge clk);
    release_rst();
    req1 = 1'b1; start1 = 8'h55; len1 = 4'd0;
    push_burst(1'b1, 8'h55, 1);
    wait_ec(1); chk("t6_gnt1", 32'({gnt1, last, addr}), 32'({1'b1, 1'b1, 8'h55}));
    req1 = 1'b0;
    wait_ec(6);
    chk("t6_drain", 32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
